// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches words from instruction memory and holds each
// on the CPU instruction input for a fixed number of cycles until HALT, halt_req or timeout.
module instr_sequencer #(
   parameter int INSTR_WIDTH      = 20,
   parameter int PC_BITS          = 5,
   parameter int CYCLES_PER_INSTR = 3,
   parameter int TIMEOUT          = 15
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   halt_req,
   output logic [PC_BITS-1:0]     imem_addr,
   output logic                   imem_rd,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   input  logic                   imem_valid,
   output logic [INSTR_WIDTH-1:0] instruction,
   output logic                   instr_valid,
   output logic [PC_BITS-1:0]     pc,
   output logic [7:0]             instr_count,
   output logic                   busy,
   output logic                   done,
   output logic                   error
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_ISSUE  = 3'd3;
   localparam logic [2:0] S_HALTED = 3'd4;

   localparam logic [3:0]         HOLD_LOAD = 4'(CYCLES_PER_INSTR - 1);
   localparam logic [3:0]         WAIT_LAST = 4'(TIMEOUT - 1);
   localparam logic [PC_BITS-1:0] PC_MAX    = {PC_BITS{1'b1}};

   logic [2:0]             state;
   logic [INSTR_WIDTH-1:0] instr_reg;
   logic [3:0]             hold_cnt;
   logic [3:0]             wait_cnt;
   logic                   halt_pend;
   logic                   is_halt_word;

   assign is_halt_word = (imem_rdata[INSTR_WIDTH-1 -: 4] == 4'hF);

   assign busy        = (state == S_FETCH) || (state == S_WAIT) || (state == S_ISSUE);
   assign done        = (state == S_HALTED);
   assign instr_valid = (state == S_ISSUE);
   assign instruction = instr_valid ? instr_reg : '0;
   assign imem_rd     = (state == S_FETCH);
   assign imem_addr   = imem_rd ? pc : '0;

   // Every path into HALTED clears halt_pend after the generic set below, so the clear wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         pc          <= '0;
         instr_count <= '0;
         error       <= 1'b0;
         halt_pend   <= 1'b0;
         instr_reg   <= '0;
         hold_cnt    <= '0;
         wait_cnt    <= '0;
      end else begin
         if (busy && halt_req) halt_pend <= 1'b1;
         case (state)
            S_IDLE, S_HALTED: begin
               if (start) begin
                  pc          <= '0;
                  instr_count <= '0;
                  error       <= 1'b0;
                  halt_pend   <= 1'b0;
                  state       <= S_FETCH;
               end
            end
            S_FETCH: begin
               wait_cnt <= '0;
               state    <= S_WAIT;
            end
            S_WAIT: begin
               if (imem_valid) begin
                  if (is_halt_word) begin
                     halt_pend <= 1'b0;
                     state     <= S_HALTED;
                  end else begin
                     instr_reg <= imem_rdata;
                     hold_cnt  <= HOLD_LOAD;
                     state     <= S_ISSUE;
                  end
               end else if (wait_cnt == WAIT_LAST) begin
                  error     <= 1'b1;
                  halt_pend <= 1'b0;
                  state     <= S_HALTED;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            S_ISSUE: begin
               if (hold_cnt == HOLD_LOAD && instr_count != 8'hFF)
                  instr_count <= instr_count + 8'd1;
               if (hold_cnt == '0) begin
                  if (halt_pend || halt_req || pc == PC_MAX) begin
                     halt_pend <= 1'b0;
                     state     <= S_HALTED;
                  end else begin
                     pc    <= pc + 1'b1;
                     state <= S_FETCH;
                  end
               end else begin
                  hold_cnt <= hold_cnt - 4'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter INSTR_WIDTH, 20, instruction word width.
REQ-002 Parameter PC_BITS, 5, instruction-memory address width (32 words).
REQ-003 Parameter CYCLES_PER_INSTR, 3, cycles each instruction is held on the CPU input (legal range 1..15).
REQ-004 Parameter TIMEOUT, 15, maximum cycles waited for imem_valid (legal range 1..15).
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle pulse that begins a run from address 0.
REQ-008 halt_req  input  1  request to stop at the next instruction boundary.
REQ-009 imem_addr  output  PC_BITS  read address to instruction memory.
REQ-010 imem_rd  output  1  one-cycle read strobe.
REQ-011 imem_rdata  input  INSTR_WIDTH  instruction word returned by memory.
REQ-012 imem_valid  input  1  imem_rdata is valid this cycle.
REQ-013 instruction  output  INSTR_WIDTH  word driven to the CPU instruction input.
REQ-014 instr_valid  output  1  instruction is being issued this cycle.
REQ-015 pc  output  PC_BITS  address of the current instruction.
REQ-016 instr_count  output  8  count of issued instructions, saturating at 255.
REQ-017 busy  output  1  high in FETCH, WAIT or ISSUE.
REQ-018 done  output  1  high in HALTED.
REQ-019 error  output  1  sticky memory-timeout flag.

Function
REQ-020 The block SHALL implement the states IDLE, FETCH, WAIT, ISSUE and HALTED, encoded in a registered state variable.
REQ-021 In IDLE, a start pulse SHALL clear pc, instr_count and error and move the block to FETCH; halt_req SHALL be ignored.
REQ-022 In FETCH, the block SHALL assert imem_rd for exactly one cycle with imem_addr = pc, then move to WAIT.
REQ-023 In WAIT, imem_valid SHALL capture imem_rdata into the instruction register; imem_valid outside WAIT SHALL be ignored.
REQ-024 If the captured word has bits [INSTR_WIDTH-1:INSTR_WIDTH-4] = 4'hF (HALT), the block SHALL go to HALTED without issuing it and without incrementing instr_count.
REQ-025 Otherwise the block SHALL enter ISSUE and load a hold counter with CYCLES_PER_INSTR-1.
REQ-026 If imem_valid is not seen within TIMEOUT cycles of entering WAIT, the block SHALL set error and go to HALTED.
REQ-027 In ISSUE, instr_valid SHALL be high and instruction SHALL remain stable for exactly CYCLES_PER_INSTR cycles.
REQ-028 On the first ISSUE cycle, instr_count SHALL increment, holding at 255 once it reaches 255.
REQ-029 On the last ISSUE cycle, the next state SHALL be selected in this order: halt pending -> HALTED; pc = 2^PC_BITS-1 -> HALTED with pc unchanged (no wrap); otherwise pc+1 and FETCH.
REQ-030 A halt_req pulse seen in FETCH, WAIT or ISSUE SHALL set a sticky halt-pending flag; the instruction in flight SHALL still be issued in full.
REQ-031 The halt-pending flag SHALL be cleared on entry to HALTED.
REQ-032 Outside ISSUE, instruction SHALL be driven to all zeros and instr_valid SHALL be low.
REQ-033 In HALTED, done SHALL be high; start SHALL clear done, pc, instr_count and error and move the block to FETCH.
REQ-034 A start pulse in FETCH, WAIT or ISSUE SHALL be ignored.
REQ-035 Simultaneous start and halt_req in IDLE or HALTED SHALL perform the start; the halt_req SHALL be discarded.

Reset
REQ-036 While rst = 0, asynchronously: state = IDLE, pc = 0, instr_count = 0, instruction = 0, and instr_valid, imem_rd, imem_addr, busy, done, error and halt-pending all = 0.
REQ-037 Reset asserted mid-operation SHALL abort any outstanding read; an imem_valid arriving after reset release SHALL be ignored.
REQ-038 After rst rises, the block SHALL stay in IDLE until a start pulse.

Verification
REQ-039 Memory holds 0x1A203, 0x20451 and 0xF0000 (1-cycle latency); pulse start -> two words issued for 3 cycles each in order; then done = 1, instr_count = 2, pc = 2.
REQ-040 Raise halt_req during WAIT for word 0 (word 0 = 0x1A203, word 1 non-HALT) -> 0x1A203 is issued for all 3 cycles; then HALTED with pc = 0 and instr_count = 1.
REQ-041 Memory never asserts imem_valid -> exactly 15 cycles after entering WAIT: error = 1, done = 1, instr_valid never asserted.
REQ-042 All 32 words non-HALT -> pc runs 0..31, instr_count = 32, HALTED with pc = 31, no wrap to 0.
REQ-043 Drop rst during the second ISSUE cycle -> all outputs are 0 immediately (before the next clock edge); after release, no activity until start.
REQ-044 In HALTED, pulse start and halt_req together -> new run from pc = 0 with done, error and instr_count cleared.
